// File: rtl/uart_rx_buffer_pkg.sv
// Shared UART receive-buffer constants and the CTS hysteresis helper.
// The optional drop counter is enabled by the UART_RX_BUF_STATS_EN macro in uart_rx_buffer.
package uart_rx_buffer_pkg;

  localparam int NUM_DATA_BITS     = 8;
  localparam int RX_BUF_DEPTH      = 16;
  localparam int RX_BUF_HIGH_WATER = 12;
  localparam int RX_BUF_LOW_WATER  = 4;

  // Hysteresis: deassert at/above high water, reassert at/below low water, else hold.
  function automatic logic cts_next(input int cnt, input int hi, input int lo, input logic cur);
    logic res;
    if (cnt >= hi) begin
      res = 1'b1;
    end else if (cnt <= lo) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port storage for the RX byte FIFO: synchronous write, asynchronous read.
module uart_rx_fifo_mem
  import uart_rx_buffer_pkg::*;
#(
  parameter int DATA_BITS = NUM_DATA_BITS,
  parameter int DEPTH     = RX_BUF_DEPTH,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_buffer.sv
// FWFT byte FIFO between the UART receiver and the monitor, with CTS hysteresis.
// Define UART_RX_BUF_STATS_EN to build the saturating dropped-byte counter.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DATA_BITS  = NUM_DATA_BITS,
  parameter int DEPTH      = RX_BUF_DEPTH,
  parameter int HIGH_WATER = RX_BUF_HIGH_WATER,
  parameter int LOW_WATER  = RX_BUF_LOW_WATER,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_done,
  input  logic                 rx_error,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [CW-1:0]        count,
  output logic                 cts_n,
  output logic                 err_sticky,
  output logic                 ovf_sticky,
  input  logic                 clear_flags,
  output logic [7:0]           drop_count
);

  logic                 rx_done_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cts_q, cts_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 push_req, pop, push_ok, err_drop, ovf_drop, drop;
  logic [DATA_BITS-1:0] mem_rd_data;

  assign empty    = (count_q == CW'(0));
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = rx_done & ~rx_done_q;
  assign pop      = rd_en & ~empty;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign push_ok  = push_req & ~rx_error & (~full | pop);
  assign err_drop = push_req & rx_error;
  assign ovf_drop = push_req & ~rx_error & full & ~pop;
  assign drop     = err_drop | ovf_drop;

  uart_rx_fifo_mem #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(rx_data),
    .rd_addr(rd_ptr_q),
    .rd_data(mem_rd_data)
  );

  always_comb begin
    wr_ptr_d = push_ok ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cts_d = cts_next(int'(count_d), HIGH_WATER, LOW_WATER, cts_q);
    // Drop events win over a same-cycle clear.
    if (err_drop) begin
      err_d = 1'b1;
    end else if (clear_flags) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (ovf_drop) begin
      ovf_d = 1'b1;
    end else if (clear_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Edge detect resets high so a done level held through reset is not captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_q <= 1'b1;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      cts_q     <= 1'b1;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cts_q     <= cts_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rd_data    = empty ? {DATA_BITS{1'b0}} : mem_rd_data;
  assign count      = count_q;
  assign cts_n      = cts_q;
  assign err_sticky = err_q;
  assign ovf_sticky = ovf_q;

`ifdef UART_RX_BUF_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    if (drop) begin
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : (drop_cnt_q + 8'd1);
    end else if (clear_flags) begin
      drop_cnt_d = 8'd0;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_count  = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected bytes, a monitor checks pops.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_error;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       cts_n;
  logic       err_sticky;
  logic       ovf_sticky;
  logic       clear_flags;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

`ifdef UART_RX_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  uart_rx_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .cts_n      (cts_n),
    .err_sticky (err_sticky),
    .ovf_sticky (ovf_sticky),
    .clear_flags(clear_flags),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle done pulse followed by one idle cycle.
  task automatic push_byte(input logic [7:0] d, input logic err, input logic expect_accept);
    rx_data  = d;
    rx_error = err;
    rx_done  = 1'b1;
    if (expect_accept) exp_q.push_back(d);
    tick();
    rx_done  = 1'b0;
    rx_error = 1'b0;
    tick();
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Monitor: on every cycle where a pop will occur, compare head against the scoreboard.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got 0x%0h, expected no data (scoreboard empty)", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_error = 1'b0;
    rd_en = 1'b0; clear_flags = 1'b0;
    repeat (3) tick();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_cts_n", int'(cts_n), 1);
    check("rst_err", int'(err_sticky), 0);
    check("rst_ovf", int'(ovf_sticky), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_rd_data", int'(rd_data), 0);
    reset = 1'b0;
    tick();
    check("cts_after_rst", int'(cts_n), 0);

    // Three single pulses, then drain.
    push_byte(8'h11, 1'b0, 1'b1); check("t1_count1", int'(count), 1);
    push_byte(8'h22, 1'b0, 1'b1); check("t1_count2", int'(count), 2);
    push_byte(8'h33, 1'b0, 1'b1); check("t1_count3", int'(count), 3);
    check("t1_head", int'(rd_data), 8'h11);
    repeat (3) pop_byte();
    check("t1_empty", int'(empty), 1);

    // Pop while empty is ignored.
    pop_byte();
    check("empty_pop_count", int'(count), 0);

    // Done level held 10 cycles captures one byte.
    rx_data = 8'hA5; rx_done = 1'b1;
    exp_q.push_back(8'hA5);
    repeat (10) tick();
    rx_done = 1'b0;
    tick();
    check("held_count", int'(count), 1);
    pop_byte();

    // Errored byte dropped, then flags cleared.
    push_byte(8'hFF, 1'b1, 1'b0);
    check("err_count", int'(count), 0);
    check("err_sticky", int'(err_sticky), 1);
    check("err_drop_cnt", int'(drop_count), STATS ? 1 : 0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    check("clr_err", int'(err_sticky), 0);
    check("clr_drop_cnt", int'(drop_count), 0);

    // Simultaneous push and pop on empty: pop ignored, byte visible next cycle.
    rx_data = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    check("pp_empty_count", int'(count), 1);
    check("pp_empty_head", int'(rd_data), 8'h77);
    pop_byte();

    // Fill to full, overflow drop, then push with simultaneous pop.
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b1);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);
    check("fill_cts", int'(cts_n), 1);
    push_byte(8'h10, 1'b0, 1'b0);
    check("ovf_sticky", int'(ovf_sticky), 1);
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(count), 16);
    check("ovf_head", int'(rd_data), 8'h00);
    check("ovf_drop_cnt", int'(drop_count), STATS ? 1 : 0);
    check("ovf_err_clear", int'(err_sticky), 0);
    rx_data = 8'h10; rx_done = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'h10);
    tick();
    rx_done = 1'b0; rd_en = 1'b0;
    tick();
    check("pp_full_count", int'(count), 16);
    check("pp_full_head", int'(rd_data), 8'h01);
    repeat (11) pop_byte();
    check("drain_count5", int'(count), 5);
    check("drain_cts5", int'(cts_n), 1);
    pop_byte();
    check("drain_cts4", int'(cts_n), 0);
    repeat (4) pop_byte();
    check("drain_empty", int'(empty), 1);

    // Hysteresis from empty: 11 keeps CTS asserted, 12 deasserts, 5 holds, 4 reasserts.
    for (int i = 0; i < 11; i++) push_byte(8'h40 + 8'(i), 1'b0, 1'b1);
    check("hy_cts11", int'(cts_n), 0);
    push_byte(8'h4B, 1'b0, 1'b1);
    check("hy_cts12", int'(cts_n), 1);
    repeat (7) pop_byte();
    check("hy_cts5", int'(cts_n), 1);
    pop_byte();
    check("hy_cts4", int'(cts_n), 0);
    repeat (4) pop_byte();

    // Reset mid-stream with 7 entries and done high.
    for (int i = 0; i < 7; i++) push_byte(8'h50 + 8'(i), 1'b0, 1'b1);
    check("mid_count7", int'(count), 7);
    reset = 1'b1; rx_data = 8'h88; rx_done = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_cts", int'(cts_n), 1);
    check("mid_rst_empty", int'(empty), 1);
    reset = 1'b0;
    repeat (3) tick();
    check("mid_nocap_count", int'(count), 0);
    rx_done = 1'b0;
    tick();
    push_byte(8'h99, 1'b0, 1'b1);
    check("mid_recap_count", int'(count), 1);
    pop_byte();
    check("final_empty", int'(empty), 1);
    check("sb_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
